// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//
// Pipeline register and operand-select stage that sits between decode /
// register-file read and the 32-bit ALU. Each cycle it resolves forwarding
// for both source operands from the EX/MEM and MEM/WB stages. It extends the
// immediate and registers the operands and control presented to the ALU.
// It supports hold (stall) and bubble insertion (flush).
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   stall, flush       hold all outputs / load a bubble (flush wins)
//   in_valid           decode presents a real instruction
//   rs_addr, rt_addr   source register addresses
//   rs_data, rt_data   register-file read data
//   imm16, alu_src,    immediate, b-operand select (1 = immediate),
//   zero_ext           and zero/sign extension select
//   alu_code_in        ALU operation from control
//   rd_addr_in,        destination register and its write enable
//   reg_write_in
//   exmem_*, memwb_*   write-back enables, destinations and values of the
//                      two later stages, used as forwarding sources
//   a, b, alu_code     registered ALU operands and operation
//   store_data         registered forwarded rt
//   rd_addr, reg_write registered destination and qualified write enable
//   valid              registered instruction-valid
//   fwd_count          saturating count of operands taken from forwarding
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [RADDR-1:0] rs_addr,
  input  logic [RADDR-1:0] rt_addr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [15:0]      imm16,
  input  logic             alu_src,
  input  logic             zero_ext,
  input  logic [2:0]       alu_code_in,
  input  logic [RADDR-1:0] rd_addr_in,
  input  logic             reg_write_in,
  input  logic             exmem_reg_write,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       alu_code,
  output logic [WIDTH-1:0] store_data,
  output logic [RADDR-1:0] rd_addr,
  output logic             reg_write,
  output logic             valid,
  output logic [15:0]      fwd_count
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       alu_code_q, alu_code_d;
  logic [WIDTH-1:0] store_data_q, store_data_d;
  logic [RADDR-1:0] rd_addr_q, rd_addr_d;
  logic             reg_write_q, reg_write_d;
  logic             valid_q, valid_d;
  logic [15:0]      fwd_count_q, fwd_count_d;

  logic             rs_from_exmem, rs_from_memwb, rs_hit;
  logic             rt_from_exmem, rt_from_memwb, rt_hit;
  logic [WIDTH-1:0] rs_fwd, rt_fwd, imm_ext;
  logic [1:0]       fwd_inc;
  logic [16:0]      cnt_sum;
  logic [15:0]      cnt_sat;

  // Forwarding and operand selection. EX/MEM holds the younger result, so it
  // is checked first. Register 0 is hard-wired and is never forwarded.
  always_comb begin
    rs_from_exmem = exmem_reg_write && (exmem_rd == rs_addr) && (rs_addr != '0);
    rs_from_memwb = memwb_reg_write && (memwb_rd == rs_addr) && (rs_addr != '0);
    rt_from_exmem = exmem_reg_write && (exmem_rd == rt_addr) && (rt_addr != '0);
    rt_from_memwb = memwb_reg_write && (memwb_rd == rt_addr) && (rt_addr != '0);
    rs_hit        = rs_from_exmem || rs_from_memwb;
    rt_hit        = rt_from_exmem || rt_from_memwb;

    if (rs_from_exmem)      rs_fwd = exmem_result;
    else if (rs_from_memwb) rs_fwd = memwb_result;
    else                    rs_fwd = rs_data;

    if (rt_from_exmem)      rt_fwd = exmem_result;
    else if (rt_from_memwb) rt_fwd = memwb_result;
    else                    rt_fwd = rt_data;

    if (zero_ext) imm_ext = {{(WIDTH-16){1'b0}}, imm16};
    else          imm_ext = {{(WIDTH-16){imm16[15]}}, imm16};

    // rt always feeds store_data, so a forwarded rt counts even when the
    // b operand comes from the immediate.
    fwd_inc = {1'b0, rs_hit} + {1'b0, rt_hit};
    cnt_sum = {1'b0, fwd_count_q} + {15'b0, fwd_inc};
    cnt_sat = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // Next-state selection: flush beats stall; a load without a real
  // instruction inserts the same bubble as a flush. The counter only moves
  // on a valid load and is left untouched by bubbles.
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    alu_code_d   = alu_code_q;
    store_data_d = store_data_q;
    rd_addr_d    = rd_addr_q;
    reg_write_d  = reg_write_q;
    valid_d      = valid_q;
    fwd_count_d  = fwd_count_q;

    if (flush || (!stall && !in_valid)) begin
      a_d          = '0;
      b_d          = '0;
      alu_code_d   = '0;
      store_data_d = '0;
      rd_addr_d    = '0;
      reg_write_d  = 1'b0;
      valid_d      = 1'b0;
    end else if (!stall) begin
      a_d          = rs_fwd;
      b_d          = alu_src ? imm_ext : rt_fwd;
      alu_code_d   = alu_code_in;
      store_data_d = rt_fwd;
      rd_addr_d    = rd_addr_in;
      reg_write_d  = reg_write_in;
      valid_d      = 1'b1;
      fwd_count_d  = cnt_sat;
    end
  end

  // State registers; reset clears everything including the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      alu_code_q   <= '0;
      store_data_q <= '0;
      rd_addr_q    <= '0;
      reg_write_q  <= 1'b0;
      valid_q      <= 1'b0;
      fwd_count_q  <= '0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      alu_code_q   <= alu_code_d;
      store_data_q <= store_data_d;
      rd_addr_q    <= rd_addr_d;
      reg_write_q  <= reg_write_d;
      valid_q      <= valid_d;
      fwd_count_q  <= fwd_count_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign alu_code   = alu_code_q;
  assign store_data = store_data_q;
  assign rd_addr    = rd_addr_q;
  assign reg_write  = reg_write_q;
  assign valid      = valid_q;
  assign fwd_count  = fwd_count_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
//
// Self-checking bench for ex_operand_stage. A behavioural model tracks the
// expected registered outputs from the input rules. Directed scenarios are
// followed by randomized traffic and a counter saturation run.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [4:0]  rs_addr, rt_addr, rd_addr_in, exmem_rd, memwb_rd;
  logic [31:0] rs_data, rt_data, exmem_result, memwb_result;
  logic [15:0] imm16;
  logic        alu_src, zero_ext, reg_write_in, exmem_reg_write, memwb_reg_write;
  logic [2:0]  alu_code_in;
  logic [31:0] a, b, store_data;
  logic [2:0]  alu_code;
  logic [4:0]  rd_addr;
  logic        reg_write, valid;
  logic [15:0] fwd_count;

  int nChecks = 0;
  int nPass   = 0;

  // Expected output state
  logic [31:0] eA, eB, eSd;
  logic [2:0]  eCode;
  logic [4:0]  eRd;
  logic        eRw, eV;
  int          eCnt;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .imm16(imm16), .alu_src(alu_src), .zero_ext(zero_ext), .alu_code_in(alu_code_in),
    .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .a(a), .b(b), .alu_code(alu_code), .store_data(store_data), .rd_addr(rd_addr),
    .reg_write(reg_write), .valid(valid), .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  // Value seen by an operand read of register addr, plus whether it came
  // from a later pipeline stage.
  function automatic logic [31:0] srcValue(input logic [4:0] addr, input logic [31:0] rf,
                                           output int hit);
    hit = 1;
    if (addr == 0) begin
      hit = 0;
      return rf;
    end
    if (exmem_reg_write && exmem_rd == addr) return exmem_result;
    if (memwb_reg_write && memwb_rd == addr) return memwb_result;
    hit = 0;
    return rf;
  endfunction

  function automatic void loadBubble();
    eA = 0; eB = 0; eSd = 0; eCode = 0; eRd = 0; eRw = 0; eV = 0;
  endfunction

  // Model of one rising edge, evaluated on the inputs currently applied.
  function automatic void modelStep();
    int hRs, hRt, sv;
    logic [31:0] vRs, vRt;
    if (reset) begin
      loadBubble();
      eCnt = 0;
    end else if (flush) begin
      loadBubble();
    end else if (stall) begin
      // hold
    end else if (!in_valid) begin
      loadBubble();
    end else begin
      vRs = srcValue(rs_addr, rs_data, hRs);
      vRt = srcValue(rt_addr, rt_data, hRt);
      sv = int'(imm16);
      if (!zero_ext && imm16 >= 16'h8000) sv = sv - 65536;
      eA = vRs;
      eSd = vRt;
      eB = alu_src ? 32'(sv) : vRt;
      eCode = alu_code_in;
      eRd = rd_addr_in;
      eRw = reg_write_in;
      eV = 1'b1;
      eCnt = eCnt + hRs + hRt;
      if (eCnt > 65535) eCnt = 65535;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".a"}, a, eA);
    checkOutput({tag, ".b"}, b, eB);
    checkOutput({tag, ".alu_code"}, 32'(alu_code), 32'(eCode));
    checkOutput({tag, ".store_data"}, store_data, eSd);
    checkOutput({tag, ".rd_addr"}, 32'(rd_addr), 32'(eRd));
    checkOutput({tag, ".reg_write"}, 32'(reg_write), 32'(eRw));
    checkOutput({tag, ".valid"}, 32'(valid), 32'(eV));
    checkOutput({tag, ".fwd_count"}, 32'(fwd_count), eCnt);
  endtask

  // Advance one clock with the current inputs, updating the model; outputs
  // are then sampled 1 time unit after the edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    reset = 0; stall = 0; flush = 0; in_valid = 0;
    rs_addr = 0; rt_addr = 0; rd_addr_in = 0; exmem_rd = 0; memwb_rd = 0;
    rs_data = 0; rt_data = 0; exmem_result = 0; memwb_result = 0;
    imm16 = 0; alu_src = 0; zero_ext = 0; reg_write_in = 0; alu_code_in = 0;
    exmem_reg_write = 0; memwb_reg_write = 0;
  endtask

  initial begin
    clearInputs();
    eCnt = 0;
    loadBubble();

    // 1. reset and basic load
    reset = 1;
    applyStimulus();
    checkAll("reset");
    reset = 0;
    in_valid = 1; rs_addr = 1; rt_addr = 2; rs_data = 32'h10; rt_data = 32'h20;
    alu_code_in = 3'b010; rd_addr_in = 3; reg_write_in = 1;
    applyStimulus();
    checkAll("basic");
    checkOutput("basic.a_const", a, 32'h10);
    checkOutput("basic.b_const", b, 32'h20);
    checkOutput("basic.cnt_const", 32'(fwd_count), 0);

    // 2. forwarding priority and register 0
    rs_addr = 5; rs_data = 32'h1234;
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hBBBB;
    applyStimulus();
    checkAll("fwd_prio");
    checkOutput("fwd_prio.a_const", a, 32'hAAAA);
    rs_addr = 0; exmem_rd = 0; memwb_rd = 0;
    applyStimulus();
    checkAll("reg0");
    checkOutput("reg0.a_const", a, 32'h1234);
    checkOutput("reg0.cnt_const", 32'(fwd_count), 1);

    // 3. immediate extension, store_data still from rt (forwarded here)
    exmem_rd = 2; exmem_result = 32'hCAFE0001;
    imm16 = 16'h8001; alu_src = 1; zero_ext = 0;
    applyStimulus();
    checkAll("sext");
    checkOutput("sext.b_const", b, 32'hFFFF8001);
    checkOutput("sext.sd_const", store_data, 32'hCAFE0001);
    zero_ext = 1;
    applyStimulus();
    checkAll("zext");
    checkOutput("zext.b_const", b, 32'h00008001);

    // 4. stall, stall+flush, in_valid=0 bubble
    exmem_reg_write = 0; memwb_reg_write = 0;
    rs_addr = 7; rs_data = 32'h5555; alu_src = 0; alu_code_in = 3'b111;
    applyStimulus();
    checkAll("preload");
    stall = 1; rs_data = 32'h9999; rt_data = 32'h7777; alu_code_in = 3'b001;
    applyStimulus();
    checkAll("stall");
    checkOutput("stall.a_const", a, 32'h5555);
    flush = 1;
    applyStimulus();
    checkAll("stall_flush");
    checkOutput("stall_flush.valid_const", 32'(valid), 0);
    stall = 0; flush = 0;
    applyStimulus();
    checkAll("reload");
    in_valid = 0;
    applyStimulus();
    checkAll("no_valid");
    checkOutput("no_valid.valid_const", 32'(valid), 0);

    // 5. reset mid-stream during a stall with a nonzero counter
    in_valid = 1; rs_addr = 4; exmem_reg_write = 1; exmem_rd = 4;
    applyStimulus();
    checkAll("pre_reset");
    stall = 1; reset = 1;
    applyStimulus();
    checkAll("mid_reset");
    checkOutput("mid_reset.cnt_const", 32'(fwd_count), 0);
    reset = 0; stall = 0;

    // Randomized traffic with small address ranges so forwarding hits often
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 5) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      rs_addr = 5'($urandom_range(0, 3));
      rt_addr = 5'($urandom_range(0, 3));
      rd_addr_in = 5'($urandom);
      exmem_rd = 5'($urandom_range(0, 3));
      memwb_rd = 5'($urandom_range(0, 3));
      exmem_reg_write = 1'($urandom);
      memwb_reg_write = 1'($urandom);
      rs_data = $urandom; rt_data = $urandom;
      exmem_result = $urandom; memwb_result = $urandom;
      imm16 = 16'($urandom);
      alu_src = 1'($urandom); zero_ext = 1'($urandom);
      alu_code_in = 3'($urandom); reg_write_in = 1'($urandom);
      applyStimulus();
      checkAll("rand");
    end

    // 6. counter saturation via double forwards
    clearInputs();
    reset = 1;
    applyStimulus();
    checkAll("sat_reset");
    reset = 0;
    in_valid = 1; rs_addr = 1; rt_addr = 2;
    exmem_reg_write = 1; exmem_rd = 1; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 2; memwb_result = 32'h22;
    for (int i = 0; i < 32767; i++) applyStimulus();
    checkAll("sat_fffe");
    checkOutput("sat_fffe.cnt_const", 32'(fwd_count), 32'hFFFE);
    applyStimulus();
    checkOutput("sat_ffff", 32'(fwd_count), 32'hFFFF);
    applyStimulus();
    applyStimulus();
    checkAll("sat_hold");
    checkOutput("sat_hold.cnt_const", 32'(fwd_count), 32'hFFFF);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
